// File: rtl/stage_mem1.sv
// stage_mem1: first memory pipeline stage. Holds one instruction from
// execute, checks alignment, runs a single data-bus transaction for loads and
// stores, and presents the (possibly load-updated) result to the write stage.
package stage_mem1_pkg;
    typedef logic [3:0] ecause_t;
    localparam ecause_t    CAUSE_LD_MISALIGN = 4'd4;
    localparam ecause_t    CAUSE_LD_FAULT    = 4'd5;
    localparam ecause_t    CAUSE_ST_MISALIGN = 4'd6;
    localparam ecause_t    CAUSE_ST_FAULT    = 4'd7;
    localparam logic [1:0] MEMOP_LOAD        = 2'd1;
    localparam logic [1:0] MEMOP_STORE       = 2'd2;
    localparam logic [1:0] SIZE_BYTE         = 2'd0;
    localparam logic [1:0] SIZE_HALF         = 2'd1;
    localparam logic [1:0] SIZE_WORD         = 2'd2;
endpackage

module stage_mem1
    import stage_mem1_pkg::*;
(
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        ex_exc,
    input  ecause_t     ex_exc_cause,
    input  logic        ex_flush,
    input  logic [29:0] ex_pc,
    input  logic [1:0]  ex_memop,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_result,
    input  logic [4:0]  ex_wb_reg,
    output logic        mem1_stall,
    input  logic        wb_stall,
    input  logic        csr_kill,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic        dbus_err,
    input  logic [31:0] dbus_rdata,
    output logic        mem1_valid_wb,
    output logic        mem1_exc,
    output ecause_t     mem1_exc_cause,
    output logic        mem1_flush,
    output logic [29:0] mem1_pc,
    output logic        mem1_busy,
    output logic [4:0]  mem1_wb_reg,
    output logic [31:0] mem1_dout
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t      r_state;
    logic        r_valid;
    logic        r_exc;
    ecause_t     r_cause;
    logic        r_kill;
    logic        r_flush;
    logic [29:0] r_pc;
    logic [1:0]  r_memop;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_dout;
    logic [4:0]  r_wb_reg;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_start;
    logic        w_bus_done;
    logic        w_held_load;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;

    assign w_is_mem    = (ex_memop == MEMOP_LOAD) || (ex_memop == MEMOP_STORE);
    assign w_misalign  = ((ex_size == SIZE_HALF) && ex_addr[0]) ||
                         ((ex_size == SIZE_WORD) && (ex_addr[1:0] != 2'b00));
    assign w_start     = ex_valid && w_is_mem && !ex_exc && !w_misalign;
    assign w_bus_done  = (r_state == S_BUS) && dbus_ack;
    assign w_held_load = (r_memop == MEMOP_LOAD);

    // Bus side is driven straight from held state, so it is stable for the
    // whole transaction and drops with the asynchronous reset of r_state.
    assign mem1_busy  = (r_state == S_BUS);
    assign mem1_stall = mem1_busy || wb_stall;
    assign dbus_req   = mem1_busy;
    assign dbus_we    = (r_memop == MEMOP_STORE);
    assign dbus_addr  = {r_addr[31:2], 2'b00};

    assign mem1_valid_wb  = r_valid && !r_exc && !r_kill && (r_wb_reg != 5'd0);
    assign mem1_exc       = r_exc;
    assign mem1_exc_cause = r_cause;
    assign mem1_flush     = r_flush && r_valid && !r_kill;
    assign mem1_pc        = r_pc;
    assign mem1_wb_reg    = r_wb_reg;
    assign mem1_dout      = r_dout;

    // Byte enables and lane-replicated store data from the held size/offset.
    always_comb begin
        dbus_be    = 4'b1111;
        dbus_wdata = r_wdata;
        case (r_size)
            SIZE_BYTE: begin
                dbus_be    = 4'b0001 << r_addr[1:0];
                dbus_wdata = {4{r_wdata[7:0]}};
            end
            SIZE_HALF: begin
                dbus_be    = 4'b0011 << r_addr[1:0];
                dbus_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                dbus_be    = 4'b1111;
                dbus_wdata = r_wdata;
            end
        endcase
    end

    // Shift the addressed lane down and extend it to 32 bits.
    always_comb begin
        w_lane      = dbus_rdata >> {r_addr[1:0], 3'b000};
        w_load_data = dbus_rdata;
        case (r_size)
            SIZE_BYTE: w_load_data = {{24{!r_unsigned && w_lane[7]}}, w_lane[7:0]};
            SIZE_HALF: w_load_data = {{16{!r_unsigned && w_lane[15]}}, w_lane[15:0]};
            default:   w_load_data = dbus_rdata;
        endcase
    end

    // Control FSM: state, valid/exception flags and the sticky kill.
    // A kill while not stalled is ignored: the held insn leaves this stage at
    // that same edge and the newly captured one has not been killed.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_exc   <= 1'b0;
            r_cause <= '0;
            r_kill  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (!wb_stall) begin
                r_valid <= ex_valid;
                r_exc   <= ex_valid && (ex_exc || (w_is_mem && w_misalign));
                r_cause <= ex_exc ? ex_exc_cause :
                           (ex_memop == MEMOP_LOAD) ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
                r_kill  <= 1'b0;
                if (w_start)
                    r_state <= S_BUS;
            end else if (csr_kill) begin
                r_valid <= 1'b0;
                r_exc   <= 1'b0;
            end
        end else begin
            // The bus transaction is never aborted; a kill only marks the insn.
            if (csr_kill)
                r_kill <= 1'b1;
            if (dbus_ack) begin
                r_state <= S_IDLE;
                r_kill  <= 1'b0;
                if (r_kill || csr_kill) begin
                    r_valid <= 1'b0;
                    r_exc   <= 1'b0;
                end else if (dbus_err) begin
                    r_exc   <= 1'b1;
                    r_cause <= w_held_load ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                end
            end
        end
    end

    // Data fields: capture when the stage advances, load data on a good ack.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            r_flush    <= 1'b0;
            r_pc       <= '0;
            r_memop    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dout     <= '0;
            r_wb_reg   <= '0;
        end else if (!mem1_stall) begin
            r_flush    <= ex_flush;
            r_pc       <= ex_pc;
            r_memop    <= ex_memop;
            r_size     <= ex_size;
            r_unsigned <= ex_unsigned;
            r_addr     <= ex_addr;
            r_wdata    <= ex_wdata;
            r_dout     <= ex_result;
            r_wb_reg   <= (ex_memop == MEMOP_STORE) ? 5'd0 : ex_wb_reg;
        end else if (w_bus_done && w_held_load && !dbus_err) begin
            r_dout     <= w_load_data;
        end
    end

endmodule

// File: tb/tb_stage_mem1.sv
// tb_stage_mem1: directed vector table, hand sequences for kill / stall /
// reset corners, then randomized traffic against a behavioural model.
module tb_stage_mem1;
    import stage_mem1_pkg::*;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_exc, ex_flush, ex_unsigned;
    ecause_t     ex_exc_cause;
    logic [29:0] ex_pc;
    logic [1:0]  ex_memop, ex_size;
    logic [31:0] ex_addr, ex_wdata, ex_result;
    logic [4:0]  ex_wb_reg;
    logic        mem1_stall, wb_stall, csr_kill;
    logic        dbus_req, dbus_we, dbus_ack, dbus_err;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        mem1_valid_wb, mem1_exc, mem1_flush, mem1_busy;
    ecause_t     mem1_exc_cause;
    logic [29:0] mem1_pc;
    logic [4:0]  mem1_wb_reg;
    logic [31:0] mem1_dout;

    int total = 0;
    int bad   = 0;

    always #5 clk_core = ~clk_core;

    stage_mem1 dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_exc(ex_exc), .ex_exc_cause(ex_exc_cause),
        .ex_flush(ex_flush), .ex_pc(ex_pc), .ex_memop(ex_memop), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_result(ex_result), .ex_wb_reg(ex_wb_reg), .mem1_stall(mem1_stall),
        .wb_stall(wb_stall), .csr_kill(csr_kill), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
        .mem1_valid_wb(mem1_valid_wb), .mem1_exc(mem1_exc), .mem1_exc_cause(mem1_exc_cause),
        .mem1_flush(mem1_flush), .mem1_pc(mem1_pc), .mem1_busy(mem1_busy),
        .mem1_wb_reg(mem1_wb_reg), .mem1_dout(mem1_dout)
    );

    typedef struct {
        logic [1:0]  memop;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] result;
        logic [31:0] rdata;
        logic [4:0]  wreg;
        logic        err;
        int          lat;
        logic        exp_req;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic        exp_exc;
        ecause_t     cause;
        logic        vwb;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[12];

    // behavioural model state
    logic        m_busy, m_kill, m_valid, m_exc, m_flush, m_load, m_uns, m_we;
    ecause_t     m_cause;
    logic [4:0]  m_wreg;
    logic [31:0] m_dout, m_addr, m_wd;
    logic [29:0] m_pc;
    logic [3:0]  m_be;
    int          m_size, m_off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_exc = 0; ex_exc_cause = '0; ex_flush = 0; ex_pc = '0;
        ex_memop = 2'd0; ex_size = 2'd0; ex_unsigned = 0; ex_addr = '0;
        ex_wdata = '0; ex_result = '0; ex_wb_reg = '0;
        wb_stall = 0; csr_kill = 0; dbus_ack = 0; dbus_err = 0; dbus_rdata = '0;
    endtask

    task automatic put_insn(input logic [1:0] memop, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] result, input logic [4:0] wreg);
        ex_valid = 1; ex_memop = memop; ex_size = size; ex_unsigned = uns;
        ex_addr = addr; ex_wdata = wdata; ex_result = result; ex_wb_reg = wreg;
        ex_pc = addr[31:2];
    endtask

    // Present one vector, answer the bus after v.lat cycles, check results.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        n = 0;
        put_insn(v.memop, v.size, v.uns, v.addr, v.wdata, v.result, v.wreg);
        tick();
        ex_valid = 0; ex_memop = 2'd0;
        chk($sformatf("v%0d req", idx), {31'd0, dbus_req}, {31'd0, v.exp_req});
        if (v.exp_req) begin
            chk($sformatf("v%0d be", idx), {28'd0, dbus_be}, {28'd0, v.be});
            chk($sformatf("v%0d addr", idx), dbus_addr, v.addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d wdata", idx), dbus_wdata, v.exp_wd);
            chk($sformatf("v%0d we", idx), {31'd0, dbus_we}, {31'd0, v.memop == 2'd2});
            for (int c = 1; c <= v.lat; c++) begin
                dbus_ack   = (c == v.lat);
                dbus_err   = v.err && (c == v.lat);
                dbus_rdata = (c == v.lat) ? v.rdata : 32'h0;
                @(negedge clk_core);
                if (mem1_stall) n++;
                tick();
            end
            dbus_ack = 0; dbus_err = 0;
            chk($sformatf("v%0d stall_cycles", idx), n, v.lat);
        end
        @(negedge clk_core);
        chk($sformatf("v%0d stall_after", idx), {31'd0, mem1_stall}, 32'd0);
        chk($sformatf("v%0d exc", idx), {31'd0, mem1_exc}, {31'd0, v.exp_exc});
        if (v.exp_exc)
            chk($sformatf("v%0d cause", idx), {28'd0, mem1_exc_cause}, {28'd0, v.cause});
        chk($sformatf("v%0d valid_wb", idx), {31'd0, mem1_valid_wb}, {31'd0, v.vwb});
        if (v.vwb)
            chk($sformatf("v%0d dout", idx), mem1_dout, v.dout);
    endtask

    function automatic logic [31:0] ext(input logic [31:0] rd, input int sz, input int off,
                                        input logic uns);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (sz == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    initial begin
        // memop size uns addr wdata result rdata wreg err lat | req be wd exc cause vwb dout
        tbl[0]  = '{2'd1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h0, 32'h80112233, 5'd3, 1'b0, 3,
                    1'b1, 4'b1000, 32'h0, 1'b0, 4'd0, 1'b1, 32'hFFFFFF80};
        tbl[1]  = '{2'd2, 2'd1, 1'b0, 32'h2001, 32'h1234, 32'h0, 32'h0, 5'd4, 1'b0, 1,
                    1'b0, 4'b0000, 32'h0, 1'b1, 4'd6, 1'b0, 32'h0};
        tbl[2]  = '{2'd2, 2'd2, 1'b0, 32'h3000, 32'hDEADBEEF, 32'h0, 32'h0, 5'd2, 1'b1, 1,
                    1'b1, 4'b1111, 32'hDEADBEEF, 1'b1, 4'd7, 1'b0, 32'h0};
        tbl[3]  = '{2'd1, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h0, 32'hBEEF1234, 5'd7, 1'b0, 1,
                    1'b1, 4'b1100, 32'h0, 1'b0, 4'd0, 1'b1, 32'h0000BEEF};
        tbl[4]  = '{2'd1, 2'd1, 1'b0, 32'h4002, 32'h0, 32'h0, 32'hBEEF1234, 5'd7, 1'b0, 2,
                    1'b1, 4'b1100, 32'h0, 1'b0, 4'd0, 1'b1, 32'hFFFFBEEF};
        tbl[5]  = '{2'd1, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h0, 32'hCAFEF00D, 5'd1, 1'b0, 2,
                    1'b1, 4'b1111, 32'h0, 1'b0, 4'd0, 1'b1, 32'hCAFEF00D};
        tbl[6]  = '{2'd2, 2'd0, 1'b0, 32'h6001, 32'h123456A5, 32'h99, 32'h0, 5'd9, 1'b0, 1,
                    1'b1, 4'b0010, 32'hA5A5A5A5, 1'b0, 4'd0, 1'b0, 32'h0};
        tbl[7]  = '{2'd1, 2'd2, 1'b0, 32'h7002, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1,
                    1'b0, 4'b0000, 32'h0, 1'b1, 4'd4, 1'b0, 32'h0};
        tbl[8]  = '{2'd1, 2'd0, 1'b1, 32'h8001, 32'h0, 32'h0, 32'h0000FF00, 5'd3, 1'b0, 1,
                    1'b1, 4'b0010, 32'h0, 1'b0, 4'd0, 1'b1, 32'h000000FF};
        tbl[9]  = '{2'd1, 2'd0, 1'b0, 32'h9000, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 2,
                    1'b1, 4'b0001, 32'h0, 1'b1, 4'd5, 1'b0, 32'h0};
        tbl[10] = '{2'd2, 2'd1, 1'b0, 32'hA002, 32'h0000BEEF, 32'h0, 32'h0, 5'd2, 1'b0, 1,
                    1'b1, 4'b1100, 32'hBEEFBEEF, 1'b0, 4'd0, 1'b0, 32'h0};
        tbl[11] = '{2'd0, 2'd0, 1'b0, 32'hB000, 32'h0, 32'h55, 32'h0, 5'd4, 1'b0, 1,
                    1'b0, 4'b0000, 32'h0, 1'b0, 4'd0, 1'b1, 32'h55};

        // reset state
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk_core);
        chk("rst req", {31'd0, dbus_req}, 32'd0);
        chk("rst valid_wb", {31'd0, mem1_valid_wb}, 32'd0);
        chk("rst exc", {31'd0, mem1_exc}, 32'd0);
        chk("rst busy", {31'd0, mem1_busy}, 32'd0);
        chk("rst stall", {31'd0, mem1_stall}, 32'd0);
        reset_n = 1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

        // kill during BUS, ack two cycles later
        tick();
        put_insn(2'd1, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 5'd2);
        tick();
        ex_valid = 0; ex_memop = 2'd0;
        chk("kill req0", {31'd0, dbus_req}, 32'd1);
        csr_kill = 1;
        tick();
        csr_kill = 0;
        @(negedge clk_core);
        chk("kill req1", {31'd0, dbus_req}, 32'd1);
        tick();
        dbus_ack = 1; dbus_rdata = 32'h1234;
        @(negedge clk_core);
        chk("kill req2", {31'd0, dbus_req}, 32'd1);
        tick();
        dbus_ack = 0;
        @(negedge clk_core);
        chk("kill req_end", {31'd0, dbus_req}, 32'd0);
        chk("kill valid_wb", {31'd0, mem1_valid_wb}, 32'd0);
        chk("kill exc", {31'd0, mem1_exc}, 32'd0);

        // ALU insn waiting behind wb_stall
        tick();
        put_insn(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h77, 5'd6);
        tick();
        wb_stall = 1;
        put_insn(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h12, 5'd5);
        repeat (2) begin
            @(negedge clk_core);
            chk("wbs stall", {31'd0, mem1_stall}, 32'd1);
            chk("wbs hold dout", mem1_dout, 32'h77);
            chk("wbs hold reg", {27'd0, mem1_wb_reg}, 32'd6);
            tick();
        end
        wb_stall = 0;
        tick();
        ex_valid = 0;
        @(negedge clk_core);
        chk("wbs dout", mem1_dout, 32'h12);
        chk("wbs reg", {27'd0, mem1_wb_reg}, 32'd5);
        chk("wbs valid_wb", {31'd0, mem1_valid_wb}, 32'd1);

        // ack while wb_stall: completes, then holds
        tick();
        put_insn(2'd1, 2'd0, 1'b1, 32'hD002, 32'h0, 32'h0, 5'd8);
        tick();
        ex_valid = 0; ex_memop = 2'd0;
        wb_stall = 1; dbus_ack = 1; dbus_rdata = 32'h00AB0000;
        tick();
        dbus_ack = 0;
        @(negedge clk_core);
        chk("ackws busy", {31'd0, mem1_busy}, 32'd0);
        chk("ackws stall", {31'd0, mem1_stall}, 32'd1);
        chk("ackws dout", mem1_dout, 32'h000000AB);
        put_insn(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h33, 5'd3);
        tick();
        @(negedge clk_core);
        chk("ackws hold", mem1_dout, 32'h000000AB);
        wb_stall = 0;
        tick();
        ex_valid = 0;
        @(negedge clk_core);
        chk("ackws next", mem1_dout, 32'h33);

        // kill of a held, upstream-excepting insn in IDLE
        put_insn(2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h44, 5'd2);
        ex_exc = 1; ex_exc_cause = 4'd2;
        tick();
        ex_valid = 0; ex_exc = 0;
        @(negedge clk_core);
        chk("ikill exc_before", {31'd0, mem1_exc}, 32'd1);
        wb_stall = 1; csr_kill = 1;
        tick();
        csr_kill = 0;
        @(negedge clk_core);
        chk("ikill exc", {31'd0, mem1_exc}, 32'd0);
        chk("ikill valid_wb", {31'd0, mem1_valid_wb}, 32'd0);
        wb_stall = 0;
        tick();

        // async reset mid-load
        put_insn(2'd1, 2'd2, 1'b0, 32'hC000, 32'h0, 32'h0, 5'd1);
        tick();
        ex_valid = 0; ex_memop = 2'd0;
        chk("areset req_before", {31'd0, dbus_req}, 32'd1);
        #2 reset_n = 0;
        #1;
        chk("areset req", {31'd0, dbus_req}, 32'd0);
        chk("areset busy", {31'd0, mem1_busy}, 32'd0);
        chk("areset valid_wb", {31'd0, mem1_valid_wb}, 32'd0);
        tick();
        reset_n = 1;
        tick();

        // randomized traffic against the model (model starts from reset)
        m_busy = 0; m_kill = 0; m_valid = 0; m_exc = 0; m_flush = 0; m_load = 0;
        m_uns = 0; m_we = 0; m_cause = '0; m_wreg = '0; m_dout = '0; m_addr = '0;
        m_wd = '0; m_pc = '0; m_be = '0; m_size = 0; m_off = 0;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] a;
            logic        mis, mem;
            wb_stall    = ($urandom_range(0, 3) == 0);
            ex_valid    = ($urandom_range(0, 9) < 7);
            ex_memop    = 2'($urandom_range(0, 2));
            ex_size     = 2'($urandom_range(0, 2));
            ex_unsigned = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (ex_size == 2'd1) a[0] = 1'b0;
                if (ex_size == 2'd2) a[1:0] = 2'b00;
            end
            ex_addr      = a;
            ex_wdata     = $urandom;
            ex_result    = $urandom;
            ex_wb_reg    = 5'($urandom);
            ex_pc        = 30'($urandom);
            ex_flush     = 1'($urandom);
            ex_exc       = ($urandom_range(0, 9) == 0);
            ex_exc_cause = 4'($urandom);
            csr_kill     = (m_busy || wb_stall) ? ($urandom_range(0, 7) == 0) : 1'b0;
            dbus_ack     = m_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            dbus_err     = dbus_ack && ($urandom_range(0, 4) == 0);
            dbus_rdata   = $urandom;

            @(negedge clk_core);
            chk("rnd stall", {31'd0, mem1_stall}, {31'd0, m_busy || wb_stall});
            chk("rnd req", {31'd0, dbus_req}, {31'd0, m_busy});
            if (m_busy) begin
                chk("rnd addr", dbus_addr, m_addr);
                chk("rnd be", {28'd0, dbus_be}, {28'd0, m_be});
                chk("rnd wdata", dbus_wdata, m_wd);
                chk("rnd we", {31'd0, dbus_we}, {31'd0, m_we});
            end else begin
                chk("rnd exc", {31'd0, mem1_exc}, {31'd0, m_exc});
                if (m_exc) chk("rnd cause", {28'd0, mem1_exc_cause}, {28'd0, m_cause});
                chk("rnd valid_wb", {31'd0, mem1_valid_wb},
                    {31'd0, m_valid && !m_exc && (m_wreg != 5'd0)});
                if (m_valid && !m_exc && (m_wreg != 5'd0)) begin
                    chk("rnd dout", mem1_dout, m_dout);
                    chk("rnd wb_reg", {27'd0, mem1_wb_reg}, {27'd0, m_wreg});
                end
                chk("rnd flush", {31'd0, mem1_flush}, {31'd0, m_valid && m_flush});
                if (m_valid) chk("rnd pc", {2'd0, mem1_pc}, {2'd0, m_pc});
            end

            @(posedge clk_core);
            if (m_busy) begin
                if (csr_kill) m_kill = 1;
                if (dbus_ack) begin
                    m_busy = 0;
                    if (m_kill) begin
                        m_valid = 0; m_exc = 0;
                    end else if (dbus_err) begin
                        m_exc = 1; m_cause = m_load ? 4'd5 : 4'd7;
                    end else if (m_load) begin
                        m_dout = ext(dbus_rdata, m_size, m_off, m_uns);
                    end
                    m_kill = 0;
                end
            end else if (!wb_stall) begin
                mis = ((ex_size == 2'd1) && (ex_addr % 2 != 0)) ||
                      ((ex_size == 2'd2) && (ex_addr % 4 != 0));
                mem = (ex_memop == 2'd1) || (ex_memop == 2'd2);
                m_valid = ex_valid; m_pc = ex_pc; m_flush = ex_flush;
                m_load  = (ex_memop == 2'd1);
                m_wreg  = (ex_memop == 2'd2) ? 5'd0 : ex_wb_reg;
                m_dout  = ex_result;
                m_exc   = ex_valid && (ex_exc || (mem && mis));
                m_cause = ex_exc ? ex_exc_cause : (m_load ? 4'd4 : 4'd6);
                m_busy  = ex_valid && mem && !ex_exc && !mis;
                m_off   = int'(ex_addr % 4);
                m_size  = int'(ex_size);
                m_uns   = ex_unsigned;
                m_addr  = ex_addr - (ex_addr % 4);
                m_we    = (ex_memop == 2'd2);
                m_be    = (ex_size == 2'd0) ? 4'(1 << m_off) :
                          (ex_size == 2'd1) ? 4'(3 << m_off) : 4'd15;
                m_wd    = (ex_size == 2'd0) ? (ex_wdata & 32'hFF) * 32'h01010101 :
                          (ex_size == 2'd1) ? (ex_wdata & 32'hFFFF) * 32'h00010001 : ex_wdata;
            end else if (csr_kill) begin
                m_valid = 0; m_exc = 0;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage_mem1.md
STAGE_MEM1 -- requirements
Module: stage_mem1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_core (rising edge) and reset_n.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
- clk_core  in  1  core clock
- reset_n  in  1  async active-low reset
- ex_valid  in  1  execute holds a valid insn
- ex_exc  in  1  insn already carries an exception
- ex_exc_cause  in  ecause_t  upstream cause
- ex_flush  in  1  insn requests pipeline flush
- ex_pc  in  30  insn pc[31:2]
- ex_memop  in  2  0 none, 1 load, 2 store
- ex_size  in  2  0 byte, 1 half, 2 word
- ex_unsigned  in  1  zero-extend load
- ex_addr  in  32  effective address
- ex_wdata  in  32  store data, low-aligned
- ex_result  in  32  ALU result for non-load insns
- ex_wb_reg  in  5  destination register (0 = none)
- mem1_stall  out  1  stage holds; execute must hold
- wb_stall  in  1  write stage holding
- csr_kill  in  1  kill the insn held in this stage
- dbus_req, dbus_we  out  1 each  bus request and write enable
- dbus_addr  out  32  word-aligned address ({addr[31:2],2'b0})
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-shifted store data
- dbus_ack, dbus_err  in  1 each  completion; error valid only with ack
- dbus_rdata  in  32  read data, valid with ack
- mem1_valid_wb  out  1  held insn valid and writes back
- mem1_exc  out  1  held insn has an exception
- mem1_exc_cause  out  ecause_t  cause
- mem1_flush  out  1  flush request
- mem1_pc  out  30  held pc[31:2]
- mem1_busy  out  1  bus transaction outstanding
- mem1_wb_reg  out  5  destination register
- mem1_dout  out  32  writeback data

Function
REQ-003 States SHALL be IDLE and BUS; mem1_busy = (state==BUS).
REQ-004 mem1_stall SHALL equal (state==BUS) | wb_stall.
REQ-005 When ~mem1_stall, the block SHALL capture all ex_* fields at the clock edge; when mem1_stall, every held field SHALL stay unchanged.
REQ-006 Misalignment SHALL be checked at capture: half with addr[0]=1, or word with addr[1:0]!=0, raises exception cause 4 (load) or 6 (store); no bus request is issued.
REQ-007 A captured valid memop with no exception from ex_exc or REQ-006 SHALL enter BUS at the same edge; otherwise the state stays IDLE.
REQ-008 In BUS, dbus_req SHALL stay 1 with dbus_addr/dbus_be/dbus_wdata/dbus_we stable until the cycle dbus_ack=1; the next state is IDLE.
REQ-009 dbus_be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word; dbus_wdata SHALL be ex_wdata replicated across lanes.
REQ-010 On a load ack, the selected lane SHALL be shifted down and sign- or zero-extended per ex_unsigned, then registered into mem1_dout. For non-loads, mem1_dout = ex_result; for stores, mem1_wb_reg is forced to 0.
REQ-011 dbus_err with ack SHALL set mem1_exc with cause 5 (load) or 7 (store) and clear mem1_valid_wb.
REQ-012 mem1_valid_wb SHALL be 1 only for a valid, non-excepting, non-killed insn with wb_reg!=0; mem1_exc SHALL be held ex_exc, or the REQ-006/REQ-011 cause.
REQ-013 csr_kill in IDLE SHALL clear the held valid and exc flags at the next edge. In BUS, the transaction SHALL NOT be aborted; a sticky kill flag is set instead, and on ack the insn retires as invalid with no exception.
REQ-014 A bus ack arriving while wb_stall=1 SHALL still complete: the state returns to IDLE, and the outputs hold until wb_stall falls.

Reset
REQ-015 While reset_n=0, the following SHALL be forced: state=IDLE, dbus_req=0, mem1_valid_wb=0, mem1_exc=0, mem1_busy=0, and kill flag=0; data fields are don't-care.
REQ-016 Reset asserted mid-BUS SHALL drop dbus_req immediately (asynchronously); the interconnect discards the transaction.

Verification
REQ-017 Load byte, addr 0x1003, rdata 0x80112233, ex_unsigned=0, ack after 3 cycles -> dbus_be=1000, mem1_dout=0xFFFFFF80, mem1_stall high for 3 cycles.
REQ-018 Store half, addr 0x2001 -> no dbus_req, mem1_exc=1, cause 6, mem1_valid_wb=0.
REQ-019 Store word, addr 0x3000, data 0xDEADBEEF, ack with err -> dbus_be=1111, mem1_exc=1, cause 7.
REQ-020 csr_kill pulse during BUS, ack two cycles later -> dbus_req held until ack; then mem1_valid_wb=0 and mem1_exc=0.
REQ-021 ALU insn (result 0x12, reg 5) captured while wb_stall=1 for 2 cycles -> outputs hold, mem1_dout=0x12 once stall clears; async reset mid-load -> dbus_req=0 without a clock edge.
